rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the 32×32 register file's single write port. Up to `NumReq` producers (ALU write-back, load unit, multi-cycle mul/div) present register writes over valid/ready handshakes. The block grants one per cycle in round-robin order and drives the register file's `write_enable`/`write_address`/`write_data` from a one-entry output register. An optional bypass path forwards the staged write to the register file's two read ports.

## Interface
- `NumReq`, 3, number of requesters (2..8)
- `PtrWidth`, 2, width of round-robin pointer, ≥ clog2(`NumReq`)
- `AddrWidth`, 5, register address width
- `DataWidth`, 32, register data width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low (0 = reset, sampled on rising `clk`)
- `req_valid`  in  `NumReq`  per-requester write request
- `req_ready`  out  `NumReq`  per-requester grant, combinational, one-hot or zero
- `req_addr`  in  `NumReq*AddrWidth`  flattened destination addresses; requester i at bits [i*AddrWidth +: AddrWidth]
- `req_data`  in  `NumReq*DataWidth`  flattened write data, same packing
- `wb_stall`  in  1  blocks all new grants while high
- `write_enable`  out  1  to register file
- `write_address`  out  `AddrWidth`  to register file
- `write_data`  out  `DataWidth`  to register file
- `idle`  out  1  high when no `req_valid` bit is set and `write_enable` is 0
- `rd_addr1`, `rd_addr2`  in  `AddrWidth`  register file read addresses (bypass only)
- `byp_hit1`, `byp_hit2`  out  1  staged write matches the read address (bypass only)
- `byp_data1`, `byp_data2`  out  `DataWidth`  forwarded data (bypass only)

## Operation
- A transfer occurs on a rising edge where `req_valid[i] & req_ready[i]`. A requester holds `req_addr`/`req_data` stable while `req_valid` is high and not granted. A requester does not drop `req_valid` before it is granted.
- Grant: if `rst`=1, `wb_stall`=0 and any valid is set, `req_ready` is asserted for the first valid requester found by scanning from `rr_ptr` upward modulo `NumReq`. Otherwise `req_ready`=0.
- Pointer: after a transfer from requester g, `rr_ptr` ← (g+1) mod `NumReq`. The pointer is unchanged in cycles with no transfer.
- Output stage: on a transfer, `write_enable` ← (addr≠0), `write_address` ← addr, `write_data` ← data. With no transfer, `write_enable` ← 0 and address/data hold their previous values.
- Address-0 requests are accepted and the pointer advances, but no write is issued.
- The register file always accepts the write, so the output stage never back-pressures. At most one grant per cycle.
- `idle` = ~|`req_valid` & ~`write_enable`.

## Timing
- Grant is same-cycle combinational. `req_ready[i]` depends on `req_valid`, `rr_ptr`, `wb_stall` and `rst` only, never on `req_data`.
- Transfer at edge T → `write_enable`=1 during cycle T..T+1 → register file updated at edge T+1. A read in the cycle after T+1 sees the new value.
- Back-to-back: a requester granted at T may be granted again at T+1 only if no other requester is valid.
- `wb_stall` rising mid-stream: no grant in that cycle. The already staged write still completes at the next edge.
- Reset (`rst`=0 at an edge): `rr_ptr`=0, `write_enable`=0, `write_address`=0, `write_data`=0. `req_ready`=0 throughout reset.
- A staged write is discarded if reset hits while `write_enable`=1, and no register file write occurs because the register file clears itself on the same reset.
- Simultaneous valid from all requesters: service order is rr_ptr, rr_ptr+1, … with no starvation. Worst-case wait is `NumReq`−1 grant cycles once unstalled.

## Configuration
- `RF_WB_BYPASS_EN` defined:
  - `byp_hitK` = `write_enable` & (`rd_addrK`≠0) & (`rd_addrK`==`write_address`).
  - `byp_dataK` = `write_data` when hit, else 0.
  - Both are combinational, for consumers to mux over the register file read data.
- Not defined: the `rd_addr*`, `byp_hit*` and `byp_data*` ports are absent and the arbiter behaviour is otherwise identical.

## Test plan
- Reset then single request: `rst`=0 for 2 cycles, then req0 valid addr=5 data=0xDEADBEEF:
  - `req_ready`=001 the same cycle.
  - Next cycle `write_enable`=1, `write_address`=5, `write_data`=0xDEADBEEF.
  - Following cycle `write_enable`=0 and `idle`=1.
- Round-robin fairness: all three requesters valid continuously for 6 grants, addrs 1/2/3 → grant order 0,1,2,0,1,2 with `write_address` sequence 1,2,3,1,2,3.
- Pointer skip: `rr_ptr`=1 after granting req0, only req0 and req2 valid → req2 granted first, then req0.
- Address-0 drop: req1 valid addr=0 data=0x1234 → `req_ready[1]`=1, `rr_ptr` advances to 2, `write_enable` stays 0.
- Stall and mid-operation reset:
  - `wb_stall`=1 with req0 valid → `req_ready`=000 for the whole stall.
  - Grant occurs the cycle `wb_stall` falls.
  - `rst`=0 the cycle after a grant → `write_enable`=0 and `rr_ptr`=0 at the next edge.
- Bypass (`RF_WB_BYPASS_EN`): staged write addr=7 data=0xA5A5A5A5, `rd_addr1`=7, `rd_addr2`=0 → `byp_hit1`=1, `byp_data1`=0xA5A5A5A5, `byp_hit2`=0, `byp_data2`=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter feeding the register file's single write port.
// Define RF_WB_BYPASS_EN to add the staged-write forwarding ports.
module rf_wb_arbiter #(
  parameter int NumReq    = 3,
  parameter int PtrWidth  = 2,
  parameter int AddrWidth = 5,
  parameter int DataWidth = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumReq-1:0]              req_valid,
  output logic [NumReq-1:0]              req_ready,
  input  logic [NumReq*AddrWidth-1:0]    req_addr,
  input  logic [NumReq*DataWidth-1:0]    req_data,
  input  logic                           wb_stall,
  output logic                           write_enable,
  output logic [AddrWidth-1:0]           write_address,
  output logic [DataWidth-1:0]           write_data,
  output logic                           idle
`ifdef RF_WB_BYPASS_EN
  ,
  input  logic [AddrWidth-1:0]           rd_addr1,
  input  logic [AddrWidth-1:0]           rd_addr2,
  output logic                           byp_hit1,
  output logic                           byp_hit2,
  output logic [DataWidth-1:0]           byp_data1,
  output logic [DataWidth-1:0]           byp_data2
`endif
);

  logic [PtrWidth-1:0]  r_ptr;
  logic                 r_we;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_data;

  logic [NumReq-1:0]    w_ready;
  logic                 w_found;
  logic                 w_xfer;
  logic                 w_in_win;
  logic [PtrWidth-1:0]  w_nxt;
  logic [AddrWidth-1:0] w_addr;
  logic [DataWidth-1:0] w_data;

  // Pass 0 scans r_ptr..NumReq-1, pass 1 wraps to 0..r_ptr-1.
  always_comb begin
    w_ready  = '0;
    w_found  = 1'b0;
    w_in_win = 1'b0;
    w_nxt    = '0;
    w_addr   = '0;
    w_data   = '0;
    if (rst && !wb_stall) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < NumReq; i++) begin
          if (p == 0) w_in_win = (PtrWidth'(i) >= r_ptr);
          else        w_in_win = (PtrWidth'(i) <  r_ptr);
          if (!w_found && req_valid[i] && w_in_win) begin
            w_found    = 1'b1;
            w_ready[i] = 1'b1;
            w_addr     = req_addr[i*AddrWidth +: AddrWidth];
            w_data     = req_data[i*DataWidth +: DataWidth];
            w_nxt      = (i == NumReq-1) ? '0 : PtrWidth'(i+1);
          end
        end
      end
    end
  end

  assign w_xfer = w_found;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr  <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_xfer) begin
      r_ptr  <= w_nxt;
      r_we   <= |w_addr;
      r_addr <= w_addr;
      r_data <= w_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  assign req_ready     = w_ready;
  assign write_enable  = r_we;
  assign write_address = r_addr;
  assign write_data    = r_data;
  assign idle          = ~|req_valid & ~r_we;

`ifdef RF_WB_BYPASS_EN
  assign byp_hit1  = r_we & (|rd_addr1) & (rd_addr1 == r_addr);
  assign byp_hit2  = r_we & (|rd_addr2) & (rd_addr2 == r_addr);
  assign byp_data1 = byp_hit1 ? r_data : '0;
  assign byp_data2 = byp_hit2 ? r_data : '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed table, corner sequences, random vs model.
// Bypass checks are compiled in when RF_WB_BYPASS_EN is defined.
module tb_rf_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wb_stall;
  logic            write_enable;
  logic [AW-1:0]   write_address;
  logic [DW-1:0]   write_data;
  logic            idle;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0]   rd_addr1, rd_addr2;
  logic            byp_hit1, byp_hit2;
  logic [DW-1:0]   byp_data1, byp_data2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .NumReq(N), .PtrWidth(2), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .wb_stall(wb_stall),
    .write_enable(write_enable), .write_address(write_address),
    .write_data(write_data), .idle(idle)
`ifdef RF_WB_BYPASS_EN
    ,
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
`endif
  );

  typedef struct {
    logic [2:0] v;
    logic       st;
    logic [4:0] a0, a1, a2;
    logic [2:0] rdy;
    logic       we;
    logic [4:0] wa;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic [2:0] v, input logic st,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [2:0] rdy,
                              input logic we, input logic [4:0] wa);
    vec_t t;
    t.v = v; t.st = st; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.rdy = rdy; t.we = we; t.wa = wa;
    return t;
  endfunction

  function automatic logic [DW-1:0] dpat(input int i, input logic [4:0] a);
    return 32'hA500_0000 + (32'(i) << 16) + 32'(a);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  int           m_ptr;
  logic         m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic         pv[N];
  logic [AW-1:0] pa[N];
  logic [DW-1:0] pd[N];

  initial begin
    logic [DW-1:0] exp_data;
    logic [N-1:0]  drv_v;
    int            g;

    tbl[0]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1);
    tbl[1]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2);
    tbl[2]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3);
    tbl[3]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1);
    tbl[4]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2);
    tbl[5]  = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3);
    tbl[6]  = mk(3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1);
    tbl[7]  = mk(3'b101, 1'b0, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3);
    tbl[8]  = mk(3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1);
    tbl[9]  = mk(3'b010, 1'b0, 5'd1, 5'd0, 5'd3, 3'b010, 1'b0, 5'd0);
    tbl[10] = mk(3'b111, 1'b0, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3);
    tbl[11] = mk(3'b001, 1'b1, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd3);
    tbl[12] = mk(3'b001, 1'b1, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd3);
    tbl[13] = mk(3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1);
    tbl[14] = mk(3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd1);

    rst = 1'b0; wb_stall = 1'b0;
    req_valid = 3'b001; req_addr = '0; req_data = '0;
`ifdef RF_WB_BYPASS_EN
    rd_addr1 = '0; rd_addr2 = '0;
`endif
    set_req(0, 5'd5, 32'hDEAD_BEEF);

    // Reset held two cycles with a pending request
    cyc();
    #3 chk("ready_in_reset", req_ready, 0);
    cyc();
    chk("rst_we", write_enable, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_data", write_data, 0);
    chk("ready_in_reset2", req_ready, 0);
    rst = 1'b1;
    #3 chk("single_ready", req_ready, 3'b001);
    cyc();
    req_valid = '0;
    chk("single_we", write_enable, 1);
    chk("single_addr", write_address, 5);
    chk("single_data", write_data, 32'hDEAD_BEEF);
    cyc();
    chk("single_we_off", write_enable, 0);
    chk("single_idle", idle, 1);

    rst = 1'b0;
    cyc();
    rst = 1'b1;
    exp_data = '0;
    for (int r = 0; r < 15; r++) begin
      req_valid = tbl[r].v;
      wb_stall  = tbl[r].st;
      set_req(0, tbl[r].a0, dpat(0, tbl[r].a0));
      set_req(1, tbl[r].a1, dpat(1, tbl[r].a1));
      set_req(2, tbl[r].a2, dpat(2, tbl[r].a2));
      #3 chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].rdy);
      if (tbl[r].rdy[0]) exp_data = dpat(0, tbl[r].a0);
      if (tbl[r].rdy[1]) exp_data = dpat(1, tbl[r].a1);
      if (tbl[r].rdy[2]) exp_data = dpat(2, tbl[r].a2);
      cyc();
      chk($sformatf("tbl%0d_we", r), write_enable, tbl[r].we);
      chk($sformatf("tbl%0d_addr", r), write_address, tbl[r].wa);
      chk($sformatf("tbl%0d_data", r), write_data, exp_data);
      chk($sformatf("tbl%0d_idle", r), idle,
          (tbl[r].v == 0) && !tbl[r].we);
    end

    // Mid-operation reset: pointer is 1 here
    req_valid = 3'b111;
    set_req(0, 5'd1, dpat(0, 5'd1));
    set_req(1, 5'd2, dpat(1, 5'd2));
    set_req(2, 5'd3, dpat(2, 5'd3));
    #3 chk("mid_ready_pre", req_ready, 3'b010);
    cyc();
    rst = 1'b0;
    #3 chk("mid_ready_rst", req_ready, 0);
    cyc();
    chk("mid_we", write_enable, 0);
    chk("mid_addr", write_address, 0);
    chk("mid_data", write_data, 0);
    rst = 1'b1;
    #3 chk("mid_ready_ptr0", req_ready, 3'b001);
    cyc();
    chk("mid_addr_after", write_address, 1);
    req_valid = '0;
    cyc();

`ifdef RF_WB_BYPASS_EN
    req_valid = 3'b001;
    set_req(0, 5'd7, 32'hA5A5_A5A5);
    cyc();
    req_valid = '0;
    rd_addr1 = 5'd7; rd_addr2 = 5'd0;
    #1;
    chk("byp_hit1", byp_hit1, 1);
    chk("byp_data1", byp_data1, 32'hA5A5_A5A5);
    chk("byp_hit2", byp_hit2, 0);
    chk("byp_data2", byp_data2, 0);
    cyc();
    chk("byp_hit1_off", byp_hit1, 0);
`endif

    // Randomized run against the model
    rst = 1'b0; req_valid = '0; wb_stall = 1'b0;
    cyc();
    rst = 1'b1;
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          pa[i] = AW'($urandom_range(0, 31));
          pd[i] = $urandom;
        end
      end
      wb_stall = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = pv[i];
        set_req(i, pa[i], pd[i]);
      end
      drv_v = req_valid;
`ifdef RF_WB_BYPASS_EN
      rd_addr1 = $urandom_range(0, 1) == 1 ? m_addr : AW'($urandom_range(0, 31));
      rd_addr2 = AW'($urandom_range(0, 31));
`endif
      g = -1;
      if (rst && !wb_stall)
        for (int k = 0; k < N; k++)
          if (g < 0 && pv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      #3 chk("rnd_ready", req_ready, g >= 0 ? (64'd1 << g) : 64'd0);
`ifdef RF_WB_BYPASS_EN
      chk("rnd_hit1", byp_hit1, m_we && rd_addr1 != 0 && rd_addr1 == m_addr);
      chk("rnd_data1", byp_data1,
          (m_we && rd_addr1 != 0 && rd_addr1 == m_addr) ? m_data : 0);
      chk("rnd_hit2", byp_hit2, m_we && rd_addr2 != 0 && rd_addr2 == m_addr);
`endif
      cyc();
      if (!rst) begin
        m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
      end else if (g >= 0) begin
        m_we = (pa[g] != 0); m_addr = pa[g]; m_data = pd[g];
        m_ptr = (g + 1) % N;
        pv[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      chk("rnd_we", write_enable, m_we);
      chk("rnd_addr", write_address, m_addr);
      chk("rnd_data", write_data, m_data);
      chk("rnd_idle", idle, (drv_v == 0) && !m_we);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
